hostif_irq_ctrl: RTL
====================

Name: hostif_irq_ctrl

Overview:
- Avalon-MM slave on the HPS lightweight bridge master (lw_bridge_m0); aggregates MN event sources into the single host interrupt line hostif_irq_i_irq.
- Also contains the POWERLINK cycle-sync timer, which is interrupt source 0.
- Host software enables sources, reads pending flags and acknowledges them with write-1-to-clear.

Parameters:
- NUM_SRC, 8, number of interrupt sources including internal sync timer (2..32)
- TIMER_WIDTH, 24, sync timer counter width in bits (8..32)
- ADDR_WIDTH, 3, word-address width of slave port

Ports:
- csi_c0_clock  in  1  system clock (100 MHz domain)
- rsi_r0_reset  in  1  synchronous active-high reset
- avs_s0_address  in  ADDR_WIDTH  word address
- avs_s0_read  in  1  read strobe
- avs_s0_write  in  1  write strobe
- avs_s0_writedata  in  32  write data
- avs_s0_byteenable  in  4  byte lanes for writes
- avs_s0_readdata  out  32  read data, valid with readdatavalid
- avs_s0_readdatavalid  out  1  read response strobe
- avs_s0_waitrequest  out  1  always 0 (no stalls)
- coe_irq_src  in  NUM_SRC-1  external event levels for sources 1..NUM_SRC-1, already synchronous to csi_c0_clock
- ins_irq_irq  out  1  interrupt to HPS (drives hostif_irq_i_irq)

Behaviour:
- Reset: all registers 0, readdata 0, readdatavalid 0, ins_irq_irq 0, timer count 0, edge-detect history 0.
- Register map (word offsets):
  - 0 PENDING: R, W1C.
  - 1 ENABLE: RW.
  - 2 CTRL: bit0 global IRQ enable, bit1 timer run; RW.
  - 3 PERIOD: RW, TIMER_WIDTH bits.
  - 4 COUNT: R.
  - 5 SET: W, write-1-sets pending (software trigger).
  - 6, 7: read 0, writes ignored.
- Only bits [NUM_SRC-1:0] exist in PENDING, ENABLE and SET; higher bits read 0.
- Byteenable masks writes per byte on all RW, W1C and W1S registers.
- Read latency is fixed at 1: readdatavalid is asserted the cycle after avs_s0_read, with readdata registered the same cycle. Otherwise readdatavalid is 0 and readdata holds its last value.
- Back-to-back reads on consecutive cycles give back-to-back valid cycles.
- Simultaneous read and write to the same offset: read returns the pre-write value.
- Edge detect: source n≥1 sets PENDING[n] on a 0→1 transition of coe_irq_src[n-1] (previous-cycle register). A level held high does not re-set after clear.
- Sync timer, counting when CTRL.bit1=1 and PERIOD≠0:
  - COUNT increments each cycle.
  - When COUNT==PERIOD-1, a one-cycle tick sets PENDING[0] and COUNT wraps to 0.
- Timer stop and period change:
  - CTRL.bit1=0 holds COUNT.
  - PERIOD=0 holds COUNT at 0 and produces no ticks.
  - Any write to PERIOD clears COUNT to 0 in the same cycle.
  - PERIOD=1 ticks every cycle.
- Pending update priority per bit, same cycle: set (edge, tick or SET) beats W1C clear. Events are never lost.
- ins_irq_irq is registered: it equals the previous cycle's value of CTRL.bit0 & |(PENDING & ENABLE). This gives 1 cycle from a PENDING update to the output.
- Disabled sources still latch pending. Enabling a source that is already pending raises the IRQ on the next cycle.
- A reset asserted mid-read drops any outstanding readdatavalid; no response follows the reset.

Test Plan:
- Reset then read offsets 0..7 → readdatavalid exactly 1 cycle after each read, all data 0, ins_irq_irq=0.
- ENABLE=0x02, CTRL=0x1, pulse coe_irq_src[0] → PENDING=0x02, ins_irq_irq=1 two cycles after the edge. Write PENDING=0x02 → PENDING=0, IRQ drops on the following cycle. A held-high source does not re-assert.
- PERIOD=5, CTRL=0x3, ENABLE=0x01 → PENDING[0] set every 5 cycles, COUNT sequence 0,1,2,3,4,0. Write PERIOD=3 mid-count → COUNT=0 and the next tick 3 cycles later.
- Timer tick and W1C of bit0 in the same cycle → PENDING[0] remains 1.
- Write SET=0x80 with byteenable=0x0 → no change. With byteenable=0x1 → PENDING=0x80. ENABLE=0 keeps IRQ low; setting ENABLE=0x80 raises it the next cycle.
- Reset asserted the cycle after a read → no readdatavalid, all registers 0.

Source files
------------

// File: rtl/hostif_irq_ctrl_if.sv
// Avalon-MM slave bus between the HPS lightweight bridge master and the
// host interrupt controller.
interface hostif_irq_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] avs_s0_address;
  logic                  avs_s0_read;
  logic                  avs_s0_write;
  logic [31:0]           avs_s0_writedata;
  logic [3:0]            avs_s0_byteenable;
  logic [31:0]           avs_s0_readdata;
  logic                  avs_s0_readdatavalid;
  logic                  avs_s0_waitrequest;

  modport master (
    output avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata, avs_s0_byteenable,
    input  avs_s0_readdata, avs_s0_readdatavalid, avs_s0_waitrequest
  );

  modport slave (
    input  avs_s0_address, avs_s0_read, avs_s0_write, avs_s0_writedata, avs_s0_byteenable,
    output avs_s0_readdata, avs_s0_readdatavalid, avs_s0_waitrequest
  );
endinterface

// File: rtl/hostif_irq_ctrl.sv
// Host interrupt aggregator: edge-detected MN event sources plus the POWERLINK
// cycle-sync timer (source 0), combined into one registered interrupt line.
module hostif_irq_ctrl #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned TIMER_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH  = 3
) (
  input  logic               csi_c0_clock,
  input  logic               rsi_r0_reset,
  hostif_irq_ctrl_if.slave   avs,
  input  logic [NUM_SRC-2:0] coe_irq_src,
  output logic               ins_irq_irq
);
  localparam logic [ADDR_WIDTH-1:0] OFF_PENDING = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_ENABLE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL    = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_PERIOD  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OFF_COUNT   = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OFF_SET     = ADDR_WIDTH'(5);

  logic [NUM_SRC-1:0]     pending, enable;
  logic [1:0]             ctrl;
  logic [TIMER_WIDTH-1:0] period, count;
  logic [NUM_SRC-2:0]     src_q;
  logic [31:0]            readdata_q;
  logic                   rdv_q;
  logic                   irq_q;

  logic [31:0]            wmask, wbits, rd_mux;
  logic                   wr_pending, wr_enable, wr_ctrl, wr_period, wr_set;
  logic                   tick;
  logic [NUM_SRC-1:0]     set_bits, clr_bits, pending_next, enable_next;
  logic [1:0]             ctrl_next;
  logic [TIMER_WIDTH-1:0] period_next, count_next;
  logic                   unused_bits;

  assign wmask = {{8{avs.avs_s0_byteenable[3]}}, {8{avs.avs_s0_byteenable[2]}},
                  {8{avs.avs_s0_byteenable[1]}}, {8{avs.avs_s0_byteenable[0]}}};
  assign wbits = avs.avs_s0_writedata & wmask;
  assign unused_bits = ^{wbits, wmask};

  assign wr_pending = avs.avs_s0_write && (avs.avs_s0_address == OFF_PENDING);
  assign wr_enable  = avs.avs_s0_write && (avs.avs_s0_address == OFF_ENABLE);
  assign wr_ctrl    = avs.avs_s0_write && (avs.avs_s0_address == OFF_CTRL);
  assign wr_period  = avs.avs_s0_write && (avs.avs_s0_address == OFF_PERIOD);
  assign wr_set     = avs.avs_s0_write && (avs.avs_s0_address == OFF_SET);

  assign tick = ctrl[1] && (period != '0) && (count == period - TIMER_WIDTH'(1));

  // Set sources win over W1C on the same bit so no event is ever dropped.
  always_comb begin
    set_bits     = {coe_irq_src & ~src_q, tick};
    clr_bits     = '0;
    if (wr_set)     set_bits = set_bits | wbits[NUM_SRC-1:0];
    if (wr_pending) clr_bits = wbits[NUM_SRC-1:0];
    pending_next = (pending & ~clr_bits) | set_bits;

    enable_next = enable;
    if (wr_enable) enable_next = (enable & ~wmask[NUM_SRC-1:0]) | wbits[NUM_SRC-1:0];
    ctrl_next = ctrl;
    if (wr_ctrl) ctrl_next = (ctrl & ~wmask[1:0]) | wbits[1:0];
    period_next = period;
    if (wr_period) period_next = (period & ~wmask[TIMER_WIDTH-1:0]) | wbits[TIMER_WIDTH-1:0];
  end

  always_comb begin
    count_next = count;
    if (wr_period || period == '0 || tick) count_next = '0;
    else if (ctrl[1])                      count_next = count + TIMER_WIDTH'(1);
  end

  always_comb begin
    rd_mux = '0;
    case (avs.avs_s0_address)
      OFF_PENDING: rd_mux = 32'(pending);
      OFF_ENABLE:  rd_mux = 32'(enable);
      OFF_CTRL:    rd_mux = 32'(ctrl);
      OFF_PERIOD:  rd_mux = 32'(period);
      OFF_COUNT:   rd_mux = 32'(count);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge csi_c0_clock) begin
    if (rsi_r0_reset) begin
      pending    <= '0;
      enable     <= '0;
      ctrl       <= '0;
      period     <= '0;
      count      <= '0;
      src_q      <= '0;
      readdata_q <= '0;
      rdv_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pending <= pending_next;
      enable  <= enable_next;
      ctrl    <= ctrl_next;
      period  <= period_next;
      count   <= count_next;
      src_q   <= coe_irq_src;
      rdv_q   <= avs.avs_s0_read;
      if (avs.avs_s0_read) readdata_q <= rd_mux;
      irq_q   <= ctrl[0] & (|(pending & enable));
    end
  end

  // A reset arriving while a response is on the bus suppresses that response.
  assign avs.avs_s0_readdatavalid = rdv_q & ~rsi_r0_reset;
  assign avs.avs_s0_readdata      = readdata_q;
  assign avs.avs_s0_waitrequest   = 1'b0;
  assign ins_irq_irq              = irq_q;
endmodule
